gt_tx_bringup_ctrl: RTL

- Sequences TX bring-up of the shared-QPLL SFP+ GTH quad in the gt_txusrclk domain.
- Generates userclk_tx_active for the transceiver wizard and synchronizes the wizard's tx-done flag.
- Waits a settle interval, then releases per-lane 10G PHY TX resets.
- Watchdogs the wizard and re-requests a TX datapath reset on timeout; supports per-lane restart without disturbing the other lane.

---
 rtl/gt_ctrl_pkg.sv | 30 +++
 rtl/gt_tx_bringup_ctrl_if.sv | 29 ++
 rtl/gt_lane_reset_pulse.sv | 36 +++
 rtl/gt_tx_bringup_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/gt_ctrl_pkg.sv
// Shared definitions for the GTH quad TX bring-up controller: FSM state encoding,
// retry counter width and counter sizing helpers.
package gt_ctrl_pkg;

  localparam int RETRY_W = 2;

  typedef enum logic [2:0] {
    ST_ACTIVATE  = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_REQ_RESET = 3'd4,
    ST_FAULT     = 3'd5
  } gt_state_e;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gt_tx_bringup_ctrl_if.sv
// Wizard/PHY-facing signal bundle of the TX bring-up controller.
// master = controller side, slave = transceiver wizard / lane PHY side.
interface gt_tx_bringup_ctrl_if
  import gt_ctrl_pkg::*;
#(
  parameter int LANES = 2
);
  logic                 reset_tx_done_async;
  logic [LANES-1:0]     lane_restart;
  logic                 userclk_tx_active;
  logic                 tx_datapath_reset_req;
  logic [LANES-1:0]     lane_tx_rst;
  logic                 tx_ready;
  logic                 fault;
  logic [RETRY_W-1:0]   retry_count;
  logic [2:0]           state;

  modport master (
    input  reset_tx_done_async, lane_restart,
    output userclk_tx_active, tx_datapath_reset_req, lane_tx_rst,
           tx_ready, fault, retry_count, state
  );

  modport slave (
    output reset_tx_done_async, lane_restart,
    input  userclk_tx_active, tx_datapath_reset_req, lane_tx_rst,
           tx_ready, fault, retry_count, state
  );
endinterface

// File: rtl/gt_lane_reset_pulse.sv
// One lane's restart handler: rising-edge detect on the restart request and a
// down-counter that holds the lane PHY TX reset for PULSE_CYCLES cycles.
module gt_lane_reset_pulse #(
  parameter int PULSE_CYCLES = 16
) (
  input  logic gt_txusrclk,
  input  logic gt_tx_reset,
  input  logic enable,
  input  logic restart,
  output logic lane_rst
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic          restart_prev_reg;
  logic [CW-1:0] cnt_reg;

  // The edge history tracks the input even while disabled, so a level already
  // high when the lane becomes eligible is not mistaken for a new request.
  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      restart_prev_reg <= 1'b0;
      cnt_reg          <= '0;
    end else begin
      restart_prev_reg <= restart;
      if (!enable)
        cnt_reg <= '0;
      else if (restart && !restart_prev_reg)
        cnt_reg <= CW'(PULSE_CYCLES);
      else if (cnt_reg != '0)
        cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign lane_rst = (cnt_reg != '0);

endmodule

// File: rtl/gt_tx_bringup_ctrl.sv
// TX bring-up sequencer for the shared-QPLL SFP+ GTH quad: userclk activation,
// tx-done synchronisation, settle, lane release, watchdog retries and lane restarts.
module gt_tx_bringup_ctrl
  import gt_ctrl_pkg::*;
#(
  parameter int LANES          = 2,
  parameter int ACTIVE_DELAY   = 4,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PULSE_CYCLES   = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 gt_txusrclk,
  input  logic                 gt_tx_reset,
  gt_tx_bringup_ctrl_if.master bus
);
  // One counter serves every timed state; it is sized for the longest interval.
  localparam int CNT_W = cnt_width(max_of4(ACTIVE_DELAY, SETTLE_CYCLES,
                                           TIMEOUT_CYCLES, PULSE_CYCLES));
  localparam logic [CNT_W-1:0]   ACTIVE_LAST  = CNT_W'(ACTIVE_DELAY - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic               done_meta_reg;
  logic               done_s_reg;
  gt_state_e          state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               active_reg;
  logic               req_reg;
  logic               all_rst_reg;
  logic               ready_reg;
  logic               fault_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic [LANES-1:0]   lane_pulse;
  logic               run_enable;

  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      done_meta_reg <= 1'b0;
      done_s_reg    <= 1'b0;
    end else begin
      done_meta_reg <= bus.reset_tx_done_async;
      done_s_reg    <= done_meta_reg;
    end
  end

  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      state_reg   <= ST_ACTIVATE;
      cnt_reg     <= '0;
      active_reg  <= 1'b0;
      req_reg     <= 1'b0;
      all_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      fault_reg   <= 1'b0;
      retry_reg   <= '0;
    end else begin
      case (state_reg)
        ST_ACTIVATE: begin
          if (cnt_reg == ACTIVE_LAST) begin
            active_reg <= 1'b1;
            cnt_reg    <= '0;
            state_reg  <= ST_WAIT_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        // A done arriving on the timeout cycle still wins.
        ST_WAIT_DONE: begin
          if (done_s_reg) begin
            cnt_reg   <= '0;
            state_reg <= ST_SETTLE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_reg <= '0;
            if (retry_reg < RETRY_LIMIT) begin
              state_reg <= ST_REQ_RESET;
              req_reg   <= 1'b1;
              if (retry_reg != '1)
                retry_reg <= retry_reg + RETRY_W'(1);
            end else begin
              state_reg <= ST_FAULT;
              fault_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_REQ_RESET: begin
          if (cnt_reg == PULSE_LAST) begin
            req_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!done_s_reg) begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_DONE;
          end else if (cnt_reg == SETTLE_LAST) begin
            cnt_reg     <= '0;
            state_reg   <= ST_RUN;
            all_rst_reg <= 1'b0;
            ready_reg   <= 1'b1;
            retry_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!done_s_reg) begin
            cnt_reg     <= '0;
            state_reg   <= ST_WAIT_DONE;
            all_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
          end
        end
        ST_FAULT: begin
          fault_reg   <= 1'b1;
          all_rst_reg <= 1'b1;
          req_reg     <= 1'b0;
          ready_reg   <= 1'b0;
        end
        default: begin
          state_reg   <= ST_FAULT;
          fault_reg   <= 1'b1;
          all_rst_reg <= 1'b1;
          req_reg     <= 1'b0;
          ready_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Gating with done_s lets a done fall in RUN pre-empt a same-cycle lane restart.
  assign run_enable = (state_reg == ST_RUN) && done_s_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      gt_lane_reset_pulse #(
        .PULSE_CYCLES (PULSE_CYCLES)
      ) u_pulse (
        .gt_txusrclk (gt_txusrclk),
        .gt_tx_reset (gt_tx_reset),
        .enable      (run_enable),
        .restart     (bus.lane_restart[gi]),
        .lane_rst    (lane_pulse[gi])
      );
    end
  endgenerate

  assign bus.userclk_tx_active     = active_reg;
  assign bus.tx_datapath_reset_req = req_reg;
  assign bus.lane_tx_rst           = {LANES{all_rst_reg}} | lane_pulse;
  assign bus.tx_ready              = ready_reg;
  assign bus.fault                 = fault_reg;
  assign bus.retry_count           = retry_reg;
  assign bus.state                 = state_reg;

endmodule
